// File: rtl/gteq_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined gteq comparator.
// Each pipeline stage carries a cmp_stage_t alongside the operand bits still to be compared.
package gteq_pkg;

   typedef struct packed {
      logic valid;
      logic decided;
      logic gt;
      logic isSigned;
   } cmp_stage_t;

   function automatic int calcStages(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit cfgOk(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/gteq_pipe_chunk_stage.sv
// One CHUNK-wide compare register stage of the gteq pipeline.
// A stage latches its verdict only for real beats; a bubble clears the valid bit and nothing else.
module gteq_chunk_stage
   import gteq_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  cmp_stage_t       prev_i,
   input  logic [CHUNK-1:0] aChunk_i,
   input  logic [CHUNK-1:0] bChunk_i,
   output cmp_stage_t       stage_o
);

   cmp_stage_t stage_q, stage_d;

   // The first differing chunk (from the MSB side) settles the outcome for good.
   always_comb begin
      stage_d = prev_i;
      if (!prev_i.decided && (aChunk_i != bChunk_i)) begin
         stage_d.decided = 1'b1;
         stage_d.gt      = (aChunk_i > bChunk_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else if (en_i) begin
         if (stage_d.valid) begin
            stage_q <= stage_d;
         end else begin
            stage_q.valid <= 1'b0;
         end
      end
   end

   assign stage_o = stage_q;

endmodule

// File: rtl/gteq_pipe.sv
// Pipelined magnitude comparator (a >= b, a > b, a == b) with a valid/ready handshake.
// Optional feature: define GTEQ_PIPE_STATS_EN to add the cmp_count/gteq_count outputs.
module gteq_pipe
   import gteq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             agteqb,
   output logic             agtb,
`ifdef GTEQ_PIPE_STATS_EN
   output logic             aeqb,
   output logic [31:0]      cmp_count,
   output logic [31:0]      gteq_count
`else
   output logic             aeqb
`endif
);

   localparam int STAGES = calcStages(WIDTH, CHUNK);
   localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;

   if (!cfgOk(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("gteq_pipe: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic             adv;
   cmp_stage_t       capStage;
   logic [WIDTH-1:0] capA, capB;
   cmp_stage_t       stgQ  [STAGES];
   logic [WIDTH-1:0] opA_q [OPS];
   logic [WIDTH-1:0] opB_q [OPS];
   logic             outValid_q, agtb_q, aeqb_q;

   // One global stall: everything moves together whenever the output slot can drain.
   assign adv      = !outValid_q || out_ready;
   assign in_ready = adv;

   // Flipping both sign bits maps two's-complement order onto unsigned order.
   always_comb begin
      capA = a;
      capB = b;
      if (is_signed) begin
         capA[WIDTH-1] = ~a[WIDTH-1];
         capB[WIDTH-1] = ~b[WIDTH-1];
      end
      capStage          = '0;
      capStage.valid    = in_valid;
      capStage.isSigned = is_signed;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < OPS; k++) begin
            opA_q[k] <= '0;
            opB_q[k] <= '0;
         end
      end else if (adv) begin
         if (in_valid) begin
            opA_q[0] <= capA;
            opB_q[0] <= capB;
         end
         for (int k = 1; k < OPS; k++) begin
            if (stgQ[k-1].valid) begin
               opA_q[k] <= opA_q[k-1];
               opB_q[k] <= opB_q[k-1];
            end
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cmp_stage_t       prev;
      logic [CHUNK-1:0] aChunk, bChunk;

      if (k == 0) begin : g_head
         assign prev   = capStage;
         assign aChunk = capA[WIDTH-1 -: CHUNK];
         assign bChunk = capB[WIDTH-1 -: CHUNK];
      end else begin : g_body
         assign prev   = stgQ[k-1];
         assign aChunk = opA_q[k-1][WIDTH-1-k*CHUNK -: CHUNK];
         assign bChunk = opB_q[k-1][WIDTH-1-k*CHUNK -: CHUNK];
      end

      gteq_chunk_stage #(.CHUNK(CHUNK)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en_i     (adv),
         .prev_i   (prev),
         .aChunk_i (aChunk),
         .bChunk_i (bChunk),
         .stage_o  (stgQ[k])
      );
   end

   // Flags only reload for real beats, so they persist after the consumer takes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         agtb_q     <= 1'b0;
         aeqb_q     <= 1'b0;
      end else if (adv) begin
         outValid_q <= stgQ[STAGES-1].valid;
         if (stgQ[STAGES-1].valid) begin
            agtb_q <= stgQ[STAGES-1].decided & stgQ[STAGES-1].gt;
            aeqb_q <= !stgQ[STAGES-1].decided;
         end
      end
   end

   assign out_valid = outValid_q;
   assign agtb      = agtb_q;
   assign aeqb      = aeqb_q;
   assign agteqb    = agtb_q | aeqb_q;

`ifdef GTEQ_PIPE_STATS_EN
   logic [31:0] cmpCount_q, gteqCount_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmpCount_q  <= '0;
         gteqCount_q <= '0;
      end else if (outValid_q && out_ready) begin
         cmpCount_q <= cmpCount_q + 32'd1;
         if (agtb_q || aeqb_q) begin
            gteqCount_q <= gteqCount_q + 32'd1;
         end
      end
   end

   assign cmp_count  = cmpCount_q;
   assign gteq_count = gteqCount_q;
`endif

endmodule

// File: tb/tb_gteq_pipe.sv
// Scoreboard bench for gteq_pipe: the driver queues expected flags on every input transfer,
// and a negedge monitor pops and compares on every output transfer.
module tb_gteq_pipe;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             s;
      logic [2:0]       exp;
   } vec_t;

   typedef struct {
      logic [2:0] flags;
      int         pushCyc;
      bit         chkLat;
   } exp_t;

   logic             clk, rst_n, in_valid, in_ready, is_signed;
   logic             out_valid, out_ready, agteqb, agtb, aeqb;
   logic [WIDTH-1:0] a, b;
`ifdef GTEQ_PIPE_STATS_EN
   logic [31:0]      cmp_count, gteq_count;
`endif

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   gteq_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .is_signed  (is_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .agteqb     (agteqb),
      .agtb       (agtb),
`ifdef GTEQ_PIPE_STATS_EN
      .aeqb       (aeqb),
      .cmp_count  (cmp_count),
      .gteq_count (gteq_count)
`else
      .aeqb       (aeqb)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [2:0] refFlags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
      logic gt, eq;
      eq = (x == y);
      gt = s ? ($signed(x) > $signed(y)) : (x > y);
      return {gt | eq, gt, eq};
   endfunction

   // Holds the beat until in_ready is seen, then queues its expected flags
   task automatic applyStimulus(input vec_t v, input bit chkLat);
      bit accepted = 1'b0;
      in_valid  = 1'b1;
      a         = v.a;
      b         = v.b;
      is_signed = v.s;
      for (int t = 0; t < 100 && !accepted; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{v.exp, cyc, chkLat});
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready never seen for a=%0h b=%0h", v.a, v.b);
      end
      in_valid = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      for (int t = 0; t < budget && sb.size() != 0; t++) begin
         @(posedge clk);
      end
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d results still outstanding", sb.size());
      end
   endtask

   // Monitor: sampled on the falling edge, so a valid && ready here is a transfer at the next rise
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: flags %0b with empty scoreboard",
                     {agteqb, agtb, aeqb});
         end else if (out_ready) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result_flags", {29'd0, agteqb, agtb, aeqb}, {29'd0, e.flags});
            if (e.chkLat) begin
               // push happens half a cycle before the accepting edge, hence STAGES+1
               checkOutput("result_latency", cyc - e.pushCyc, STAGES + 1);
            end
         end else begin
            checkOutput("stall_flags_hold", {29'd0, agteqb, agtb, aeqb}, {29'd0, sb[0].flags});
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
         end
      end
   end

   vec_t t123 [5] = '{
      '{16'hAAAA, 16'hAAAA, 1'b0, 3'b101},
      '{16'h8000, 16'h7FFF, 1'b0, 3'b110},
      '{16'h8000, 16'h7FFF, 1'b1, 3'b000},
      '{16'h1234, 16'h1235, 1'b0, 3'b000},
      '{16'hFFFF, 16'h0000, 1'b0, 3'b110}
   };

   vec_t t4 [8] = '{
      '{16'h0001, 16'h0000, 1'b0, 3'b110},
      '{16'h0000, 16'h0001, 1'b0, 3'b000},
      '{16'hFFFF, 16'hFFFF, 1'b1, 3'b101},
      '{16'hFFFF, 16'h0001, 1'b1, 3'b000},
      '{16'h7FFF, 16'h8000, 1'b1, 3'b110},
      '{16'h00F0, 16'h00F0, 1'b0, 3'b101},
      '{16'h1000, 16'h0FFF, 1'b0, 3'b110},
      '{16'hABCD, 16'hABCE, 1'b1, 3'b000}
   };

   vec_t t6 [10] = '{
      '{16'h0005, 16'h0003, 1'b0, 3'b110},
      '{16'h0003, 16'h0005, 1'b0, 3'b000},
      '{16'h0010, 16'h0010, 1'b0, 3'b101},
      '{16'hFFFE, 16'hFFFF, 1'b1, 3'b000},
      '{16'hFFFF, 16'hFFFE, 1'b1, 3'b110},
      '{16'h8000, 16'h8000, 1'b1, 3'b101},
      '{16'h0100, 16'h00FF, 1'b0, 3'b110},
      '{16'h7000, 16'h9000, 1'b0, 3'b000},
      '{16'h7000, 16'h9000, 1'b1, 3'b110},
      '{16'h0000, 16'h0001, 1'b1, 3'b000}
   };

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      is_signed = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("reset_flags", {29'd0, agteqb, agtb, aeqb}, 32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] equality, sign and LSB-chunk vectors");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(t123[i], 1'b1);
         waitDrain(20);
      end
      checkOutput("flags_kept_after_drain", {29'd0, agteqb, agtb, aeqb}, 32'b110);
      checkOutput("out_valid_after_drain", {31'd0, out_valid}, 32'd0);

      $display("[TB] back-to-back stream");
      for (int i = 0; i < 8; i++) applyStimulus(t4[i], 1'b1);
      waitDrain(40);

      $display("[TB] stream with 5-cycle consumer stall");
      fork
         begin
            for (int i = 0; i < 8; i++) applyStimulus(t4[i], 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      waitDrain(60);

      $display("[TB] reset with transactions in flight");
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(t4[i], 1'b0);
      for (int t = 0; t < 20 && !out_valid; t++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("stalled_before_reset", {31'd0, out_valid}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mid_reset_flags", {29'd0, agteqb, agtb, aeqb}, 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         checkOutput("idle_after_reset", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      $display("[TB] ten compares after reset");
      for (int i = 0; i < 10; i++) applyStimulus(t6[i], 1'b1);
      waitDrain(40);
`ifdef GTEQ_PIPE_STATS_EN
      checkOutput("cmp_count", cmp_count, 32'd10);
      checkOutput("gteq_count", gteq_count, 32'd6);
`endif

      $display("[TB] random vectors against reference model");
      for (int i = 0; i < 30; i++) begin
         vec_t v;
         v.a   = WIDTH'($urandom);
         v.b   = (i % 4 == 0) ? v.a : WIDTH'($urandom);
         v.s   = 1'($urandom_range(0, 1));
         v.exp = refFlags(v.a, v.b, v.s);
         applyStimulus(v, 1'b1);
      end
      waitDrain(60);
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
